prio_grant_arbiter: RTL and testbench
=====================================

# prio_grant_arbiter

Sequential arbiter that shares one resource among `N` requesters, such as a shared bus driver or a single `assign`-driven net fed through a priority mux. The base policy is fixed priority, with index 0 highest, matching the `? :` priority chains used throughout the datapath. The arbiter adds aging promotion against starvation, a bounded hold time with preemption, and a one-cycle dead turnaround between owners. Its outputs directly drive the select inputs of the shared resource's mux.

## Interface
Parameters:
- `N`, 4: number of requesters (≥2).
- `AGE_MAX`, 7: a waiting requester whose age counter saturates at this value is promoted above fixed priority.
- `HOLD_MAX`, 8: maximum grant length in cycles when another requester is waiting (≥2).
- `W`, `$clog2(N)`: width of the grant index.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  level request per requester; held high while the resource is wanted.
- `gnt`  out  N  one-hot grant (all-zero when no owner); registered.
- `gnt_valid`  out  1  OR of `gnt`; registered.
- `gnt_idx`  out  W  index of the current owner; 0 when `gnt_valid`=0; registered.
- `revoke`  out  1  one-cycle pulse in the cycle after a forced preemption.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, `revoke`=0, all ages 0, hold counter 0.
- States:
  - IDLE: no owner. If any `req` is high, pick a winner and go to GRANT; `gnt` is set at the same edge.
  - GRANT: owner `k` holds the resource. The hold counter increments each cycle and saturates at `HOLD_MAX`.
    - `req[k]`=0 → GAP (normal release, no `revoke`).
    - Else if hold counter = `HOLD_MAX`-1 and some `req[j]`=1 with j≠k → GAP and pulse `revoke`.
    - Otherwise stay in GRANT.
  - GAP: `gnt`=0 for exactly one cycle (turnaround). At its edge, arbitrate exactly as in IDLE: a winner → GRANT, none → IDLE.
- Winner selection (combinational, evaluated on the current `req` and ages):
  - Candidates = `req`. The promoted set = candidates whose age = `AGE_MAX`.
  - If the promoted set is non-empty, the winner is its lowest index. Otherwise the winner is the lowest-index candidate.
- Age counters (`$clog2(AGE_MAX+1)` bits each), per requester i:
  - Cleared when `req[i]`=0 or when i is granted.
  - Otherwise increment, saturating at `AGE_MAX`, on every cycle `req[i]`=1 and i is not the owner. This includes GAP cycles.
- A preempted owner that keeps `req` high becomes a normal candidate; its age starts from 0.
- Hold counter clears on every entry to GRANT.
- `HOLD_MAX` preemption applies only when a competitor is waiting. A sole requester may hold indefinitely.
- Simultaneous release and preemption condition in the same cycle: treated as a normal release; `revoke` stays 0.
- Reset mid-grant: all outputs drop asynchronously to their reset values. Arbitration restarts from IDLE on the first edge after `rst_n` rises.

## Timing
- Request in IDLE at cycle t → `gnt` high at t+1.
- Release (`req[k]` low) at cycle t → `gnt[k]` low at t+1 (GAP) → next owner's `gnt` high at t+2.
- Preemption:
  - The grant entered at edge e lasts cycles e..e+HOLD_MAX-1.
  - `gnt` is low and `revoke`=1 at e+HOLD_MAX.
  - The new owner is granted at e+HOLD_MAX+1.
- No combinational path from `req` to any output.
- At most one `gnt` bit is high at any time, and it is never high in GAP.

## Structure
- Package `prio_arb_pkg`:
  - `state_t` enum {IDLE, GRANT, GAP}.
  - Function `find_first(logic [N-1:0])` returning the lowest set index.
- Sub-module `prio_pick`: purely combinational winner select.
  - Inputs: `req`, ages.
  - Outputs: `win_valid`, `win_idx`.
  - Instantiated once.
- Top module: FSM, hold counter, age counters, output registers.

## Test plan
- Single request: `req`=0100 at t → `gnt`=0100 and `gnt_idx`=2 at t+1. Drop `req` → `gnt`=0 next cycle → IDLE.
- Priority: `req`=0101 together → owner 0. After it releases → GAP → `gnt`=0100.
- Aging (`AGE_MAX`=3): `req[2]` held high. `req[0]` is re-asserted immediately after each release with 2-cycle holds → `req[2]` promoted and granted no later than the second arbitration, ahead of `req[0]`.
- Preemption (`HOLD_MAX`=8): `req[0]` held forever, `req[1]` asserted at grant cycle 2 → `gnt[0]` for 8 cycles, then `revoke`=1 with `gnt`=0, then `gnt`=0010.
- Boundaries:
  - Sole requester holds 20 cycles → no `revoke`.
  - Release on the preemption cycle → `revoke`=0.
- Reset: `rst_n` low mid-GRANT → `gnt`=0 and `gnt_valid`=0 immediately. After release, `req`=1000 → `gnt`=1000 one edge later.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared types and helpers for the priority grant arbiter.
// Holds the FSM state encoding and a lowest-set-index search.
package prio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Widest requester vector the helper accepts; callers zero-extend.
   localparam int MAX_N = 32;
   localparam int MAX_W = 5;

   // Lowest set index of v; 0 when v is all-zero.
   function automatic logic [MAX_W-1:0] find_first(
      input logic [MAX_N-1:0] v
   );
      logic [MAX_W-1:0] idx;
      idx = '0;
      for (int i = MAX_N - 1; i >= 0; i--) begin
         if (v[i]) idx = MAX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational winner select for the grant arbiter.
// Ports: req, age (per requester) in; win_valid, win_idx out.
module prio_pick
   import prio_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int AGE_MAX = 7,
   parameter int W       = $clog2(N),
   parameter int AW      = $clog2(AGE_MAX + 1)
) (
   input  logic [N-1:0]         req,
   input  logic [N-1:0][AW-1:0] age,
   output logic                 win_valid,
   output logic [W-1:0]         win_idx
);

   logic [N-1:0] promoted;

   always_comb begin
      promoted = '0;
      for (int i = 0; i < N; i++) begin
         promoted[i] = req[i] && (age[i] == AW'(AGE_MAX));
      end
   end

   // A saturated age lifts a requester above fixed priority.
   always_comb begin
      win_valid = |req;
      if (|promoted) begin
         win_idx = W'(find_first(MAX_N'(promoted)));
      end else begin
         win_idx = W'(find_first(MAX_N'(req)));
      end
   end

endmodule

// File: rtl/prio_grant_arbiter.sv
// prio_grant_arbiter: fixed-priority arbiter with aging, bounded hold,
// preemption and a one-cycle dead turnaround between owners.
// Ports: clk, rst_n, req[N] in; gnt[N], gnt_valid, gnt_idx, revoke out.
module prio_grant_arbiter
   import prio_arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int AGE_MAX  = 7,
   parameter int HOLD_MAX = 8,
   parameter int W        = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx,
   output logic         revoke
);

   localparam int AW = $clog2(AGE_MAX + 1);
   localparam int HW = $clog2(HOLD_MAX + 1);

   state_t               state_q, state_d;
   logic [N-1:0]         gnt_q, gnt_d;
   logic                 gnt_valid_q, gnt_valid_d;
   logic [W-1:0]         gnt_idx_q, gnt_idx_d;
   logic                 revoke_q, revoke_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [N-1:0][AW-1:0] age_q, age_d;

   logic                 win_valid;
   logic [W-1:0]         win_idx;
   logic                 grant_now;
   logic                 rival;

   prio_pick #(
      .N       (N),
      .AGE_MAX (AGE_MAX),
      .W       (W),
      .AW      (AW)
   ) u_pick (
      .req       (req),
      .age       (age_q),
      .win_valid (win_valid),
      .win_idx   (win_idx)
   );

   // gnt_q is one-hot on the owner, so this is "someone else waits".
   assign rival = |(req & ~gnt_q);

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_idx_d   = gnt_idx_q;
      revoke_d    = 1'b0;
      hold_d      = hold_q;
      grant_now   = 1'b0;
      unique case (state_q)
         IDLE, GAP: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_idx_d   = '0;
            hold_d      = '0;
            state_d     = IDLE;
            if (win_valid) begin
               grant_now      = 1'b1;
               state_d        = GRANT;
               gnt_d[win_idx] = 1'b1;
               gnt_valid_d    = 1'b1;
               gnt_idx_d      = win_idx;
            end
         end
         GRANT: begin
            if (!req[gnt_idx_q]
                || (hold_q == HW'(HOLD_MAX - 1) && rival)) begin
               // Release wins over preemption: revoke only if still held.
               revoke_d    = req[gnt_idx_q];
               state_d     = GAP;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               gnt_idx_d   = '0;
            end else if (hold_q != HW'(HOLD_MAX)) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      age_d = age_q;
      for (int i = 0; i < N; i++) begin
         if (!req[i]
             || (grant_now && win_idx == W'(i))
             || (state_q == GRANT && gnt_q[i])) begin
            age_d[i] = '0;
         end else if (age_q[i] != AW'(AGE_MAX)) begin
            age_d[i] = age_q[i] + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
         revoke_q    <= 1'b0;
         hold_q      <= '0;
         age_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
         revoke_q    <= revoke_d;
         hold_q      <= hold_d;
         age_q       <= age_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_idx   = gnt_idx_q;
   assign revoke    = revoke_q;

endmodule

// File: tb/tb_prio_grant_arbiter.sv
// tb_prio_grant_arbiter: directed bench for prio_grant_arbiter.
// Scenario tasks with hand-computed expectations, one summary line.
module tb_prio_grant_arbiter;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [W-1:0] gnt_idx;
   logic         revoke;

   int n_cmp;
   int n_bad;

   prio_grant_arbiter #(
      .N        (N),
      .AGE_MAX  (3),
      .HOLD_MAX (8),
      .W        (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .revoke    (revoke)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      req = '0;
      step();
      step();
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({gnt, gnt_valid, gnt_idx, revoke} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outs got=%b want=0",
                  {gnt, gnt_valid, gnt_idx, revoke});
      end
      #3 rst_n = 1'b1;
      step();
      n_cmp++;
      if (gnt !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_idle gnt=%b want=0000", gnt);
      end
   endtask

   task automatic test_single();
      req = 4'b0100;
      step();
      n_cmp++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL single_gnt gnt=%b idx=%0d v=%b want 0100/2/1",
                  gnt, gnt_idx, gnt_valid);
      end
      req = 4'b0000;
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || revoke !== 1'b0) begin
         n_bad++;
         $display("FAIL single_gap gnt=%b v=%b rv=%b want 0000/0/0",
                  gnt, gnt_valid, revoke);
      end
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_idx !== 2'd0) begin
         n_bad++;
         $display("FAIL single_idle gnt=%b idx=%0d want 0000/0",
                  gnt, gnt_idx);
      end
   endtask

   task automatic test_priority();
      req = 4'b0101;
      step();
      n_cmp++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
         n_bad++;
         $display("FAIL prio_first gnt=%b idx=%0d want 0001/0",
                  gnt, gnt_idx);
      end
      req = 4'b0100;
      step();
      n_cmp++;
      if (gnt !== 4'b0000) begin
         n_bad++;
         $display("FAIL prio_gap gnt=%b want 0000", gnt);
      end
      step();
      n_cmp++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
         n_bad++;
         $display("FAIL prio_second gnt=%b idx=%0d want 0100/2",
                  gnt, gnt_idx);
      end
      go_idle();
   endtask

   task automatic test_aging();
      req = 4'b0101;
      step();
      n_cmp++;
      if (gnt !== 4'b0001) begin
         n_bad++;
         $display("FAIL age_first gnt=%b want 0001", gnt);
      end
      step();
      step();
      req = 4'b0100;
      step();
      n_cmp++;
      if (gnt !== 4'b0000) begin
         n_bad++;
         $display("FAIL age_gap gnt=%b want 0000", gnt);
      end
      req = 4'b0101;
      step();
      n_cmp++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
         n_bad++;
         $display("FAIL age_promote gnt=%b idx=%0d want 0100/2",
                  gnt, gnt_idx);
      end
      go_idle();
   endtask

   task automatic test_preempt();
      req = 4'b0001;
      step();
      step();
      req = 4'b0011;
      n_cmp++;
      if (gnt !== 4'b0001) begin
         n_bad++;
         $display("FAIL pre_hold2 gnt=%b want 0001", gnt);
      end
      repeat (6) begin
         step();
         n_cmp++;
         if (gnt !== 4'b0001 || revoke !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_hold gnt=%b rv=%b want 0001/0",
                     gnt, revoke);
         end
      end
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || revoke !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_revoke gnt=%b rv=%b want 0000/1",
                  gnt, revoke);
      end
      step();
      n_cmp++;
      if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || revoke !== 1'b0) begin
         n_bad++;
         $display("FAIL pre_new gnt=%b idx=%0d rv=%b want 0010/1/0",
                  gnt, gnt_idx, revoke);
      end
      go_idle();
   endtask

   task automatic test_sole_hold();
      req = 4'b1000;
      repeat (20) begin
         step();
         n_cmp++;
         if (gnt !== 4'b1000 || revoke !== 1'b0) begin
            n_bad++;
            $display("FAIL sole_hold gnt=%b rv=%b want 1000/0",
                     gnt, revoke);
         end
      end
      go_idle();
   endtask

   task automatic test_release_on_preempt();
      req = 4'b0001;
      step();
      step();
      req = 4'b0011;
      repeat (6) step();
      req = 4'b0010;
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || revoke !== 1'b0) begin
         n_bad++;
         $display("FAIL rel_pre gnt=%b rv=%b want 0000/0",
                  gnt, revoke);
      end
      step();
      n_cmp++;
      if (gnt !== 4'b0010) begin
         n_bad++;
         $display("FAIL rel_pre_next gnt=%b want 0010", gnt);
      end
      go_idle();
   endtask

   task automatic test_reset_mid();
      req = 4'b0001;
      step();
      n_cmp++;
      if (gnt !== 4'b0001) begin
         n_bad++;
         $display("FAIL rst_pre gnt=%b want 0001", gnt);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
         n_bad++;
         $display("FAIL rst_async gnt=%b v=%b idx=%0d want 0000/0/0",
                  gnt, gnt_valid, gnt_idx);
      end
      req = 4'b1000;
      #2 rst_n = 1'b1;
      step();
      n_cmp++;
      if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
         n_bad++;
         $display("FAIL rst_regrant gnt=%b idx=%0d want 1000/3",
                  gnt, gnt_idx);
      end
      go_idle();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      req   = '0;
      test_reset();
      test_single();
      test_priority();
      test_aging();
      test_preempt();
      test_sole_hold();
      test_release_on_preempt();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
